mult_div_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath. It sits beside `alu`, consumes the register-file read ports (rs, rt) and feeds the writeback mux for MFHI/MFLO. It executes MULT, MULTU, DIV and DIVU over 34 cycles. While an operation is in flight it raises `busy`, which the controller uses to hold `pc` and suppress `RegWrite`.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/twos_negate.sv | 18 +
 rtl/mult_div_unit.sv | 153 +++++++++++++++
 tb/tb_mult_div_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   OP_*    : values of the 2-bit op input
//   state_t : control states of the unit
//   ITER_W  : width of the iteration counter
package mdu_pkg;

  localparam int unsigned ITER_W = 6;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } state_t;

endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational conditional two's-complement negate.
//   neg      in  1  negate when high
//   data_in  in  W  operand
//   data_out out W  neg ? -data_in : data_in
module twos_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    if (neg) data_out = ~data_in + W'(1);
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
//   clk, rst          clock; synchronous active-high reset
//   start, op         launch operation (sampled only in IDLE)
//   rs_data, rt_data  multiplicand/dividend, multiplier/divisor
//   mthi, mtlo        write rs_data into HI / LO (only in IDLE)
//   hi, lo            HI/LO registers
//   busy              high whenever an operation is in flight
//   done              one-cycle pulse after an operation writes HI/LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            mthi,
  input  logic            mtlo,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);

  localparam logic [ITER_W-1:0] LAST = ITER_W'(XLEN - 1);

  state_t              state, state_nx;
  logic [ITER_W-1:0]   cnt;
  logic [1:0]          op_q;
  logic [XLEN-1:0]     rs_q, rt_q, opnd;
  logic                neg_res, neg_rem;
  logic                is_div, is_signed;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic [XLEN-1:0]     quo_fix, rem_fix;
  logic [2*XLEN-1:0]   prod_fix;

  // Shared register: {upper[XLEN:0], lower[XLEN-1:0]}.
  // Multiply: upper = partial product (with carry), lower = multiplier shifting out.
  // Divide:   upper = partial remainder, lower = dividend shifting out / quotient in.
  logic [2*XLEN:0]     acc, acc_nx;
  logic [XLEN:0]       sum, rem_sh;

  assign is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);
  assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);

  twos_negate #(.W(XLEN)) u_abs_a (
    .neg(is_signed & rs_q[XLEN-1]), .data_in(rs_q), .data_out(abs_a)
  );
  twos_negate #(.W(XLEN)) u_abs_b (
    .neg(is_signed & rt_q[XLEN-1]), .data_in(rt_q), .data_out(abs_b)
  );
  twos_negate #(.W(2*XLEN)) u_fix_prod (
    .neg(neg_res), .data_in(acc[2*XLEN-1:0]), .data_out(prod_fix)
  );
  twos_negate #(.W(XLEN)) u_fix_quo (
    .neg(neg_res), .data_in(acc[XLEN-1:0]), .data_out(quo_fix)
  );
  twos_negate #(.W(XLEN)) u_fix_rem (
    .neg(neg_rem), .data_in(acc[2*XLEN-1:XLEN]), .data_out(rem_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:    if (start) state_nx = PREP;
      PREP:    state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // One iteration step for the selected operation.
  always_comb begin
    sum    = acc[2*XLEN:XLEN] + {1'b0, opnd};
    rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    acc_nx = acc;
    if (is_div) begin
      if (rem_sh >= {1'b0, opnd})
        acc_nx = {rem_sh - {1'b0, opnd}, acc[XLEN-2:0], 1'b1};
      else
        acc_nx = {rem_sh, acc[XLEN-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_nx = {1'b0, sum, acc[XLEN-1:1]};
      else        acc_nx = {1'b0, acc[2*XLEN:XLEN], acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      opnd    <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX);
      unique case (state)
        IDLE: begin
          if (mthi) hi <= rs_data;
          if (mtlo) lo <= rs_data;
          if (start) begin
            op_q <= op;
            rs_q <= rs_data;
            rt_q <= rt_data;
          end
        end
        PREP: begin
          cnt     <= '0;
          opnd    <= is_div ? abs_b : abs_a;
          acc     <= {{(XLEN+1){1'b0}}, is_div ? abs_a : abs_b};
          neg_res <= is_signed & (rs_q[XLEN-1] ^ rt_q[XLEN-1]);
          neg_rem <= is_signed & rs_q[XLEN-1];
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + ITER_W'(1);
        end
        FIX: begin
          if (is_div) begin
            // Division by zero reports the raw dividend, bypassing sign fix.
            if (rt_q == '0) begin
              lo <= '1;
              hi <= rs_q;
            end else begin
              lo <= quo_fix;
              hi <= rem_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] model_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
    longint pa, pb, q, r;
    pa = $signed(a);
    pb = $signed(b);
    case (o)
      2'b00: return pa * pb;
      2'b01: return {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hffffffff};
        q = pa / pb;
        r = pa % pb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hffffffff};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Cycle model: 34 busy cycles after an accepted start, result then done.
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_done = 1'b0;
  int          busy_left = 0;
  logic [63:0] pend = '0;
  bit          model_live = 1'b0;

  always @(posedge clk) begin
    model_live <= 1'b1;
    if (rst) begin
      exp_hi    <= '0;
      exp_lo    <= '0;
      exp_done  <= 1'b0;
      busy_left <= 0;
    end else begin
      exp_done <= 1'b0;
      if (busy_left > 0) begin
        busy_left <= busy_left - 1;
        if (busy_left == 1) begin
          exp_hi   <= pend[63:32];
          exp_lo   <= pend[31:0];
          exp_done <= 1'b1;
        end
      end else begin
        if (mthi) exp_hi <= rs_data;
        if (mtlo) exp_lo <= rs_data;
        if (start) begin
          pend      <= model_result(op, rs_data, rt_data);
          busy_left <= 34;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      check("busy", busy, busy_left > 0);
      check("done", done, exp_done);
    end
  end

  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(posedge clk);
    #2;
    start = 1'b0; op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic wait_done(input bit disturb, output int busy_cnt);
    bit got_done;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (disturb && busy_cnt == 10) begin
        start = 1'b1; mthi = 1'b1; op = 2'b11; rs_data = 32'h1234;
      end
      if (disturb && busy_cnt == 13) begin
        start = 1'b0; mthi = 1'b0;
      end
    end
    check("done_seen", got_done, 1'b1);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int bc;
    @(negedge clk);
    launch(o, a, b);
    wait_done(1'b0, bc);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
    check({name, "_busy_cycles"}, bc, 34);
  endtask

  initial begin
    int bc;
    int dcount;

    check("pin_mult", model_result(2'b00, 32'hfffffffd, 32'd7), 64'hffffffff_ffffffeb);
    check("pin_div", model_result(2'b10, 32'hfffffff9, 32'd2), 64'hffffffff_fffffffd);
    check("pin_divovf", model_result(2'b10, 32'h80000000, 32'hffffffff), 64'h00000000_80000000);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    run("multu_max", 2'b01, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001);
    @(negedge clk);
    check("done_single_pulse", done, 0);

    run("mult_neg3x7", 2'b00, 32'hfffffffd, 32'd7, 32'hffffffff, 32'hffffffeb);
    run("mult_min_sq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    run("div_m7_2", 2'b10, 32'hfffffff9, 32'd2, 32'hffffffff, 32'hfffffffd);
    run("div_ovf", 2'b10, 32'h80000000, 32'hffffffff, 32'h0, 32'h80000000);
    run("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    // Back-to-back: launch in the cycle done is high.
    launch(2'b11, 32'd100, 32'd0);
    wait_done(1'b0, bc);
    check("divu_by0_hi", hi, 32'd100);
    check("divu_by0_lo", lo, 32'hffffffff);
    check("divu_by0_busy_cycles", bc, 34);

    @(negedge clk);
    mtlo = 1'b1; rs_data = 32'hABCD;
    @(posedge clk);
    #2 mtlo = 1'b0;
    @(negedge clk);
    check("mtlo_lo", lo, 32'hABCD);
    check("mtlo_hi", hi, 32'd100);
    check("mtlo_no_done", done, 0);

    @(negedge clk);
    launch(2'b01, 32'd6, 32'd7);
    wait_done(1'b1, bc);
    check("ignore_busy_hi", hi, 32'd0);
    check("ignore_busy_lo", lo, 32'd42);

    @(negedge clk);
    launch(2'b00, 32'd5, 32'd5);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run("after_rst", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
